// File: rtl/regread_stage.sv
// Decode-stage operand reader: regfile select, write-back bypass, RAW scoreboard.
// Define REGREAD_BYPASS_EN to forward same-cycle write-backs instead of stalling on them.
module regread_stage #(
    parameter int         W       = 32,
    parameter int         NREG    = 8,
    parameter logic [3:0] NONE_ID = 4'hF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      srcA,
    input  logic [3:0]      srcB,
    input  logic [3:0]      in_dst,
    input  logic [W-1:0]    r0,
    input  logic [W-1:0]    r1,
    input  logic [W-1:0]    r2,
    input  logic [W-1:0]    r3,
    input  logic [W-1:0]    r4,
    input  logic [W-1:0]    r5,
    input  logic [W-1:0]    r6,
    input  logic [W-1:0]    r7,
    input  logic [3:0]      dstE,
    input  logic [W-1:0]    valE,
    input  logic [3:0]      dstM,
    input  logic [W-1:0]    valM,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    valA,
    output logic [W-1:0]    valB,
    output logic [3:0]      out_dst,
    output logic [NREG-1:0] busy
);

    localparam int IW = $clog2(NREG);

    // The regfile exposes exactly eight read ports, so NREG is expected to be 8.
    logic [W-1:0] rf [8];
    assign rf[0] = r0;
    assign rf[1] = r1;
    assign rf[2] = r2;
    assign rf[3] = r3;
    assign rf[4] = r4;
    assign rf[5] = r5;
    assign rf[6] = r6;
    assign rf[7] = r7;

    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         hazA;
    logic         hazB;
    logic         accept;

    function automatic logic isReg(input logic [3:0] s);
        return s < 4'(NREG);
    endfunction

    function automatic logic [W-1:0] pick(input logic [3:0] s);
        logic [W-1:0] v;
        v = '0;
        if (isReg(s)) begin
`ifdef REGREAD_BYPASS_EN
            // M is written after E in the regfile, so it is the newer value.
            priority case (1'b1)
                (dstM == s): v = valM;
                (dstE == s): v = valE;
                default:     v = rf[s[IW-1:0]];
            endcase
`else
            v = rf[s[IW-1:0]];
`endif
        end
        return v;
    endfunction

    function automatic logic hazard(input logic [3:0] s);
        logic h;
        h = 1'b0;
        if (isReg(s)) begin
`ifdef REGREAD_BYPASS_EN
            h = busy[s[IW-1:0]] & (dstE != s) & (dstM != s);
`else
            h = busy[s[IW-1:0]] | (dstE == s) | (dstM == s);
`endif
        end
        return h;
    endfunction

    // Operand selection and RAW hazard detection for both sources.
    always_comb begin
        opA  = pick(srcA);
        opB  = pick(srcB);
        hazA = hazard(srcA);
        hazB = hazard(srcB);
    end

    assign in_ready = (~out_valid | out_ready) & ~hazA & ~hazB;
    assign accept   = in_valid & in_ready;

    // Output register: load on accept, drop valid once consumed, else hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            valA      <= '0;
            valB      <= '0;
            out_dst   <= NONE_ID;
        end else if (accept) begin
            out_valid <= 1'b1;
            valA      <= opA;
            valB      <= opB;
            out_dst   <= in_dst;
        end else if (out_valid & out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Scoreboard: write-backs retire producers, a new accept claims its dst.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                busy[i] <= (accept & (in_dst == 4'(i)))
                         | (busy[i] & ~((dstE == 4'(i)) | (dstM == 4'(i))));
            end
        end
    end

endmodule

// File: tb/tb_regread_stage.sv
// Randomized bench for regread_stage against a rule-level reference model.
// Follows REGREAD_BYPASS_EN the same way the design does.
module tb_regread_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  srcA, srcB, in_dst;
    logic [31:0] rf [8];
    logic [3:0]  dstE, dstM;
    logic [31:0] valE, valM;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] valA, valB;
    logic [3:0]  out_dst;
    logic [7:0]  busy;

    int checks = 0;
    int failures = 0;

    // Reference state
    bit          mValid;
    logic [31:0] mA, mB;
    logic [3:0]  mDst;
    bit          mBusy [8];

    regread_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .srcA(srcA), .srcB(srcB), .in_dst(in_dst),
        .r0(rf[0]), .r1(rf[1]), .r2(rf[2]), .r3(rf[3]),
        .r4(rf[4]), .r5(rf[5]), .r6(rf[6]), .r7(rf[7]),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .out_valid(out_valid), .out_ready(out_ready),
        .valA(valA), .valB(valB), .out_dst(out_dst),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] busyVec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = mBusy[i];
        return v;
    endfunction

    function automatic logic [31:0] refVal(input logic [3:0] s);
        int id = int'(s);
        if (id >= 8) return 32'h0;
`ifdef REGREAD_BYPASS_EN
        if (dstM == s) return valM;
        if (dstE == s) return valE;
`endif
        return rf[id];
    endfunction

    function automatic bit refStall(input logic [3:0] s);
        int id = int'(s);
        bit wb;
        if (id >= 8) return 1'b0;
        wb = (int'(dstE) == id) || (int'(dstM) == id);
`ifdef REGREAD_BYPASS_EN
        return mBusy[id] && !wb;
`else
        return mBusy[id] || wb;
`endif
    endfunction

    task automatic modelReset();
        mValid = 0;
        mA = 0;
        mB = 0;
        mDst = 4'hF;
        for (int i = 0; i < 8; i++) mBusy[i] = 0;
    endtask

    task automatic checkOut(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(mValid));
        chk({tag, ".valA"}, valA, mA);
        chk({tag, ".valB"}, valB, mB);
        chk({tag, ".out_dst"}, 32'(out_dst), 32'(mDst));
        chk({tag, ".busy"}, 32'(busy), 32'(busyVec()));
    endtask

    // Called at a negedge with inputs already driven; ends at next negedge.
    task automatic cyc(input string tag);
        bit expRdy, acc;
        logic [31:0] nA, nB;
        bit nb [8];
        #1;
        expRdy = (!mValid || out_ready) && !refStall(srcA) && !refStall(srcB);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(expRdy));
        acc = in_valid && expRdy;
        nA = refVal(srcA);
        nB = refVal(srcB);
        for (int i = 0; i < 8; i++) begin
            bit wb = (int'(dstE) == i) || (int'(dstM) == i);
            nb[i] = (acc && int'(in_dst) == i) || (mBusy[i] && !wb);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) mBusy[i] = nb[i];
        if (acc) begin
            mValid = 1;
            mA = nA;
            mB = nB;
            mDst = in_dst;
        end else if (mValid && out_ready) begin
            mValid = 0;
        end
        checkOut(tag);
        @(negedge clock);
    endtask

    task automatic idle();
        in_valid = 0;
        srcA = 4'hF;
        srcB = 4'hF;
        in_dst = 4'hF;
        dstE = 4'hF;
        dstM = 4'hF;
        valE = 0;
        valM = 0;
    endtask

    function automatic logic [3:0] rndId();
        int k = int'($urandom_range(0, 11));
        return (k >= 8) ? 4'((k == 11) ? 15 : 8 + k - 8) : 4'(k);
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 32'h100 + 32'(i);
        rf[1] = 5;
        rf[2] = 7;
        rf[3] = 32'h33;
        idle();
        out_ready = 1;
        reset = 0;
        modelReset();
        #12;
        checkOut("reset");
        reset = 1;
        @(negedge clock);

        // Basic accept
        in_valid = 1;
        srcA = 1;
        srcB = 2;
        in_dst = 3;
        cyc("t1");
        chk("t1.valA5", valA, 32'd5);
        chk("t1.valB7", valB, 32'd7);
        chk("t1.busy3", 32'(busy[3]), 32'd1);

        // RAW stall then release through E write-back
        srcA = 3;
        srcB = 4'hF;
        in_dst = 4'hF;
        for (int k = 0; k < 3; k++) begin
            cyc("t2.stall");
            chk("t2.noready", 32'(in_ready), 32'd0);
        end
        dstE = 3;
        valE = 32'hABCDEF98;
        cyc("t2.wb");
`ifdef REGREAD_BYPASS_EN
        chk("t2.bypass", valA, 32'hABCDEF98);
`else
        dstE = 4'hF;
        cyc("t2.late");
        chk("t2.r3", valA, 32'h33);
`endif
        chk("t2.clear", 32'(busy[3]), 32'd0);

        // M beats E
        srcA = 4;
        dstE = 4;
        valE = 1;
        dstM = 4;
        valM = 2;
        cyc("t3");
`ifdef REGREAD_BYPASS_EN
        chk("t3.mprio", valA, 32'd2);
`endif
        idle();

        // Backpressure then back-to-back
        in_valid = 1;
        out_ready = 0;
        cyc("t4.fill");
        srcA = 0;
        cyc("t4.hold");
        chk("t4.blocked", 32'(in_ready), 32'd0);
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            srcA = 4'(k + 5);
            cyc("t4.b2b");
        end

        // Set beats clear
        in_dst = 5;
        dstM = 5;
        valM = 32'h55;
        cyc("t5");
        chk("t5.busy5", 32'(busy[5]), 32'd1);
        idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 8; i++) rf[i] = $urandom;
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            srcA = rndId();
            srcB = ($urandom_range(0, 5) == 0) ? srcA : rndId();
            in_dst = rndId();
            dstE = rndId();
            dstM = rndId();
            valE = $urandom;
            valM = $urandom;
            cyc("rnd");
        end

        // Reset in the middle of a stall
        idle();
        out_ready = 0;
        in_valid = 1;
        in_dst = 6;
        cyc("t6.claim");
        srcA = 6;
        in_dst = 4'hF;
        cyc("t6.stall");
        #2;
        reset = 0;
        #1;
        modelReset();
        chk("t6.rst.valid", 32'(out_valid), 32'd0);
        chk("t6.rst.busy", 32'(busy), 32'd0);
        @(negedge clock);
        checkOut("t6.rst");
        reset = 1;
        idle();
        out_ready = 1;
        cyc("t6.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
